// File: rtl/pb_ctrl_pkg.sv
// Shared types and constants for the push-button scan/event controller.
package pb_ctrl_pkg;

  // Event kinds carried on the output event port.
  typedef enum logic [1:0] {
    PB_EVT_PRESS   = 2'd0,
    PB_EVT_RELEASE = 2'd1,
    PB_EVT_LONG    = 2'd2
  } pb_evt_e;

  localparam int EVT_W = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pb_rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester found
// scanning upward from ptr, wrapping from N-1 back to 0.
module pb_rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_vld
);

  int idx;

  // Walk the N positions starting at ptr; the first active request wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/pb_scan_event_ctrl.sv
// Debounces N push buttons off one shared sample tick, turns accepted level
// changes into PRESS/RELEASE events and serialises them onto a single
// valid/ready port through a round-robin arbiter.
// Optional feature macro: PB_LONGPRESS_EN adds per-button hold counters that
// raise one LONG event per press after LONG_TICKS ticks held.
module pb_scan_event_ctrl
  import pb_ctrl_pkg::*;
#(
  parameter  int N_PB         = 4,
  parameter  int TICK_DIV     = 1000,
  parameter  int STABLE_TICKS = 8,
  parameter  int LONG_TICKS   = 500,
  localparam int IDW          = (N_PB > 1) ? $clog2(N_PB) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_PB-1:0] pb_raw,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDW-1:0]  evt_id,
  output pb_evt_e         evt_type,
  output logic [N_PB-1:0] pb_status,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int TCW = $clog2(TICK_DIV);
  localparam int SCW = $clog2(STABLE_TICKS + 1);

  logic [N_PB-1:0] sync_a, pb_sync;
  logic [TCW-1:0]  tick_cnt;
  logic            tick;
  logic [SCW-1:0]  stab_cnt [N_PB];
  logic [N_PB-1:0] raise_press, raise_rel, raise_long;
  logic [N_PB-1:0] press_pend, rel_pend, long_pend, req;
  logic [N_PB-1:0] clr_press, clr_rel, clr_long;
  logic [IDW-1:0]  rr_ptr, gnt_idx;
  logic            gnt_vld, load, ovf_set;
  pb_evt_e         gnt_type;

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is always updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      sync_a  <= '0;
      pb_sync <= '0;
    end else begin
      sync_a  <= pb_raw;
      pb_sync <= sync_a;
    end
  end

  // Shared sample-tick prescaler: one-cycle tick every TICK_DIV clocks.
  assign tick = (tick_cnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TCW'(1);
  end

  // Per-button debounce: accept a level after STABLE_TICKS differing ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_status   <= '0;
      raise_press <= '0;
      raise_rel   <= '0;
      // NOTE: this counter array is a handful of flops, not a RAM, so it is
      // reset like any other state; a true memory array would not be.
      for (int i = 0; i < N_PB; i++) stab_cnt[i] <= '0;
    end else begin
      raise_press <= '0;
      raise_rel   <= '0;
      if (tick) begin
        for (int i = 0; i < N_PB; i++) begin
          if (pb_sync[i] != pb_status[i]) begin
            if (stab_cnt[i] == SCW'(STABLE_TICKS - 1)) begin
              pb_status[i]   <= pb_sync[i];
              stab_cnt[i]    <= '0;
              raise_press[i] <= pb_sync[i];
              raise_rel[i]   <= ~pb_sync[i];
            end else begin
              stab_cnt[i] <= stab_cnt[i] + SCW'(1);
            end
          end else begin
            stab_cnt[i] <= '0;
          end
        end
      end
    end
  end

`ifdef PB_LONGPRESS_EN
  localparam int HCW = $clog2(LONG_TICKS + 1);
  logic [HCW-1:0] hold_cnt [N_PB];

  // Hold timer: counts ticks while pressed, fires LONG once, then saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raise_long <= '0;
      for (int i = 0; i < N_PB; i++) hold_cnt[i] <= '0;
    end else begin
      raise_long <= '0;
      if (tick) begin
        for (int i = 0; i < N_PB; i++) begin
          if (pb_status[i]) begin
            if (hold_cnt[i] != HCW'(LONG_TICKS)) begin
              hold_cnt[i] <= hold_cnt[i] + HCW'(1);
              if (hold_cnt[i] == HCW'(LONG_TICKS - 1)) raise_long[i] <= 1'b1;
            end
          end else begin
            hold_cnt[i] <= '0;
          end
        end
      end
    end
  end
`else
  assign raise_long = '0;
`endif

  // The output register may take a new event when empty or being drained.
  assign load = ~evt_valid | evt_ready;
  assign req  = press_pend | rel_pend | long_pend;

  pb_rr_arbiter #(.N(N_PB)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Pick the granted button's highest-priority flag: PRESS > LONG > RELEASE.
  always_comb begin
    clr_press = '0;
    clr_rel   = '0;
    clr_long  = '0;
    gnt_type  = PB_EVT_PRESS;
    if (load && gnt_vld) begin
      if (press_pend[gnt_idx]) begin
        clr_press[gnt_idx] = 1'b1;
      end else if (long_pend[gnt_idx]) begin
        clr_long[gnt_idx] = 1'b1;
        gnt_type          = PB_EVT_LONG;
      end else begin
        clr_rel[gnt_idx] = 1'b1;
        gnt_type         = PB_EVT_RELEASE;
      end
    end
  end

  // A raise hitting a flag that is still set (and not leaving now) is lost.
  assign ovf_set = |((press_pend & ~clr_press & raise_press) |
                     (rel_pend   & ~clr_rel   & raise_rel)   |
                     (long_pend  & ~clr_long  & raise_long));

  // Pending flags (raise wins over same-cycle clear) and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pend <= '0;
      rel_pend   <= '0;
      long_pend  <= '0;
      ovf        <= 1'b0;
    end else begin
      press_pend <= (press_pend & ~clr_press) | raise_press;
      rel_pend   <= (rel_pend   & ~clr_rel)   | raise_rel;
      long_pend  <= (long_pend  & ~clr_long)  | raise_long;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Output event register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= PB_EVT_PRESS;
      rr_ptr    <= '0;
    end else if (load) begin
      evt_valid <= gnt_vld;
      if (gnt_vld) begin
        evt_id   <= gnt_idx;
        evt_type <= gnt_type;
        rr_ptr   <= (gnt_idx == IDW'(N_PB - 1)) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pb_scan_event_ctrl.sv
// Self-checking bench for pb_scan_event_ctrl: directed step table, a mid-hold
// reset sequence and a randomized run against a behavioural model.
// Honours PB_LONGPRESS_EN when the design is built with it.
module tb_pb_scan_event_ctrl;
  import pb_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LT = 5;
  localparam int EP = 0;
  localparam int ER = 1;
  localparam int EL = 2;
`ifdef PB_LONGPRESS_EN
  localparam int LP = 1;
`else
  localparam int LP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pb_raw = '0;
  logic         evt_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_id;
  pb_evt_e      evt_type;
  logic [N-1:0] pb_status;
  logic         ovf;

  pb_scan_event_ctrl #(
    .N_PB(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb_raw    (pb_raw),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_type  (evt_type),
    .pb_status (pb_status),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { int id; int ty; } ev_t;
  logic [N-1:0] m_s1, m_s2, m_status;
  int           m_phase;
  int           m_diff [N];
  int           m_hold [N];
  bit           m_pend [N][3];
  ev_t          m_raised [$];
  bit           m_valid, m_ovf;
  int           m_id, m_type, m_rr;

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_status = '0; m_phase = 0;
    for (int b = 0; b < N; b++) begin
      m_diff[b] = 0; m_hold[b] = 0;
      for (int t = 0; t < 3; t++) m_pend[b][t] = 0;
    end
    m_raised.delete();
    m_valid = 0; m_ovf = 0; m_id = 0; m_type = 0; m_rr = 0;
  endfunction

  // One clock edge of the specified behaviour, from pre-edge values.
  function automatic void model_step();
    bit tick, found, ovf_set;
    int i;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = (m_phase == TD - 1);
    if (!m_valid || evt_ready) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        i = (m_rr + k) % N;
        if (!found && (m_pend[i][EP] || m_pend[i][ER] || m_pend[i][EL])) begin
          found  = 1;
          m_id   = i;
          m_type = m_pend[i][EP] ? EP : (m_pend[i][EL] ? EL : ER);
          m_pend[i][m_type] = 0;
          m_rr   = (i + 1) % N;
        end
      end
      m_valid = found;
    end
    ovf_set = 0;
    foreach (m_raised[j]) begin
      if (m_pend[m_raised[j].id][m_raised[j].ty]) ovf_set = 1;
      else m_pend[m_raised[j].id][m_raised[j].ty] = 1;
    end
    m_raised.delete();
    if (ovf_set) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (tick) begin
      for (int b = 0; b < N; b++) begin
        if (LP != 0) begin
          if (m_status[b]) begin
            if (m_hold[b] < LT) begin
              m_hold[b]++;
              if (m_hold[b] == LT) m_raised.push_back('{b, EL});
            end
          end else begin
            m_hold[b] = 0;
          end
        end
        if (m_s2[b] != m_status[b]) begin
          m_diff[b]++;
          if (m_diff[b] == ST) begin
            m_status[b] = m_s2[b];
            m_diff[b]   = 0;
            m_raised.push_back('{b, m_s2[b] ? EP : ER});
          end
        end else begin
          m_diff[b] = 0;
        end
      end
    end
    m_s2    = m_s1;
    m_s1    = pb_raw;
    m_phase = tick ? 0 : m_phase + 1;
  endfunction

  // ---------------- cycle driver and event monitor ----------------
  typedef struct { int id; int ty; int cyc; } acc_t;
  acc_t acc_q [$];
  int   cyc = 0;

  task automatic cycle();
    logic [9:0] act, exp;
    if (rst_n && evt_valid && evt_ready) acc_q.push_back('{int'(evt_id), int'(evt_type), cyc});
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    act = {evt_valid, evt_valid ? {evt_id, 2'(evt_type)} : 4'h0, pb_status, ovf};
    exp = {m_valid, m_valid ? {2'(m_id), 2'(m_type)} : 4'h0, m_status, m_ovf};
    check("model {valid,id,type,status,ovf}", 32'(act), 32'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- directed step table ----------------
  typedef struct {
    bit rst; logic [3:0] raw; bit ready; bit clr; int cycles;
    logic [3:0] st; bit vld; bit ov; int nevt; int id; int ty; bit pair;
  } vec_t;
  vec_t tbl [16];

  initial begin
    int n0, sz, rmode, bit_i;

    // Reset with all buttons held: every output must be zero.
    pb_raw = 4'hF; evt_ready = 1'b1; rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    check("reset evt_valid", evt_valid, 0);
    check("reset evt_id", evt_id, 0);
    check("reset evt_type", 2'(evt_type), 0);
    check("reset pb_status", pb_status, 0);
    check("reset ovf", ovf, 0);
    rst_n = 1'b1;
    pb_raw = '0;

    //          rst raw    rdy clr cyc  st     vld ov nevt id ty  pair
    tbl[0]  = '{0, 4'h0,   1, 0, 20, 4'h0,   0, 0, 0,  0, EP, 0};
    tbl[1]  = '{0, 4'b0100,1, 0, 18, 4'b0100,0, 0, 1,  2, EP, 0};
    tbl[2]  = '{0, 4'b0100,1, 0, 22, 4'b0100,0, 0, LP, 2, EL, 0};
    tbl[3]  = '{0, 4'b0100,1, 0, 40, 4'b0100,0, 0, 0,  0, EP, 0};
    tbl[4]  = '{0, 4'h0,   1, 0, 40, 4'h0,   0, 0, 1,  2, ER, 0};
    tbl[5]  = '{0, 4'b0010,1, 0, 5,  4'h0,   0, 0, 0,  0, EP, 0};
    tbl[6]  = '{0, 4'h0,   1, 0, 30, 4'h0,   0, 0, 0,  0, EP, 0};
    tbl[7]  = '{1, 4'b1001,0, 0, 14, 4'b1001,1, 0, 0,  0, EP, 0};
    tbl[8]  = '{0, 4'b1001,1, 0, 2,  4'b1001,0, 0, 2,  3, EP, 1};
    tbl[9]  = '{0, 4'h0,   1, 0, 20, 4'h0,   0, 0, 2,  3, ER, 1};
    tbl[10] = '{1, 4'b0010,0, 0, 16, 4'b0010,1, 0, 0,  1, EP, 0};
    tbl[11] = '{0, 4'h0,   0, 0, 16, 4'h0,   1, 0, 0,  1, EP, 0};
    tbl[12] = '{0, 4'b0010,0, 0, 16, 4'b0010,1, 0, 0,  1, EP, 0};
    tbl[13] = '{0, 4'h0,   0, 0, 16, 4'h0,   1, 1, 0,  1, EP, 0};
    tbl[14] = '{0, 4'h0,   0, 1, 4,  4'h0,   1, 0, 0,  1, EP, 0};
    tbl[15] = '{0, 4'h0,   1, 0, 6,  4'h0,   0, 0, 3,  1, ER, 0};

    for (int v = 0; v < 16; v++) begin
      if (tbl[v].rst) do_reset();
      pb_raw    = tbl[v].raw;
      evt_ready = tbl[v].ready;
      ovf_clr   = tbl[v].clr;
      n0 = acc_q.size();
      for (int c = 0; c < tbl[v].cycles; c++) begin
        cycle();
        ovf_clr = 1'b0;
      end
      sz = acc_q.size();
      check($sformatf("v%0d pb_status", v), pb_status, tbl[v].st);
      check($sformatf("v%0d evt_valid", v), evt_valid, tbl[v].vld);
      check($sformatf("v%0d ovf", v), ovf, tbl[v].ov);
      check($sformatf("v%0d events accepted", v), sz - n0, tbl[v].nevt);
      if (tbl[v].nevt > 0 && sz > n0) begin
        check($sformatf("v%0d last id", v), acc_q[sz-1].id, tbl[v].id);
        check($sformatf("v%0d last type", v), acc_q[sz-1].ty, tbl[v].ty);
      end else if (tbl[v].nevt == 0 && tbl[v].vld) begin
        check($sformatf("v%0d held id", v), evt_id, tbl[v].id);
        check($sformatf("v%0d held type", v), 2'(evt_type), tbl[v].ty);
      end
      if (tbl[v].pair) begin
        if (sz - n0 >= 2) begin
          check($sformatf("v%0d tie first id", v), acc_q[sz-2].id, 0);
          check($sformatf("v%0d tie second id", v), acc_q[sz-1].id, 3);
          check($sformatf("v%0d tie back-to-back", v), acc_q[sz-1].cyc - acc_q[sz-2].cyc, 1);
        end else begin
          check($sformatf("v%0d tie event count", v), sz - n0, 2);
        end
      end
    end

    // Asynchronous reset while an event is held: output drops without a clock.
    evt_ready = 1'b0;
    pb_raw    = 4'b0100;
    repeat (20) cycle();
    check("hold evt_valid", evt_valid, 1);
    check("hold evt_id", evt_id, 2);
    check("hold evt_type", 2'(evt_type), EP);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async reset evt_valid", evt_valid, 0);
    check("async reset pb_status", pb_status, 0);
    check("async reset ovf", ovf, 0);

    // Randomized run: button toggles, varying back-pressure, occasional clears.
    pb_raw = '0;
    do_reset();
    rmode = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 250) == 0) rmode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 23) == 0) begin
        bit_i = int'($urandom_range(0, N - 1));
        pb_raw[bit_i] = ~pb_raw[bit_i];
      end
      case (rmode)
        0:       evt_ready = 1'b1;
        1:       evt_ready = ($urandom_range(0, 9) < 7);
        default: evt_ready = ($urandom_range(0, 9) < 2);
      endcase
      ovf_clr = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
